// File: rtl/rocketcpu_codec_init.sv
// rocketcpu_codec_init: boot-time WM8731 control-word sequencer, Wishbone master into the codec SPI shifter.
// Build option `CODEC_INIT_RETRY_EN: a timed-out word is re-issued up to MAX_RETRY times before ERROR.
module rocketcpu_codec_init #(
    parameter int GAP_CYCLES     = 16,
    parameter int RESET_WAIT     = 1024,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRY      = 3
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_start,
    output logic [15:0] o_wb_dat,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic        i_wb_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [3:0]  o_index
);
    localparam int CW = $clog2((RESET_WAIT > TIMEOUT_CYCLES ? RESET_WAIT : TIMEOUT_CYCLES) + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef CODEC_INIT_RETRY_EN
    localparam int RETRIES = MAX_RETRY;
`else
    localparam int RETRIES = 0;
`endif
    localparam logic [3:0] LAST = 4'd10;

    typedef enum logic [2:0] {S_IDLE, S_XFER, S_GAP, S_DONE, S_ERROR} state_t;

    state_t         r_state, w_state;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [RW-1:0]  r_retry, w_retry;
    logic [3:0]     r_idx, w_idx;
    logic [15:0]    r_dat, w_dat;
    logic           r_again, w_again;

    function automatic logic [15:0] rom(input logic [3:0] i);
        case (i)
            4'd0:    rom = 16'h1E00;
            4'd1:    rom = 16'h0C00;
            4'd2:    rom = 16'h0E02;
            4'd3:    rom = 16'h1000;
            4'd4:    rom = 16'h0812;
            4'd5:    rom = 16'h0A00;
            4'd6:    rom = 16'h0017;
            4'd7:    rom = 16'h0217;
            4'd8:    rom = 16'h0479;
            4'd9:    rom = 16'h0679;
            4'd10:   rom = 16'h1201;
            default: rom = 16'h0000;
        endcase
    endfunction

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_retry <= '0;
            r_idx   <= '0;
            r_dat   <= '0;
            r_again <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_retry <= w_retry;
            r_idx   <= w_idx;
            r_dat   <= w_dat;
            r_again <= w_again;
        end
    end

    // r_again marks a gap that follows a timeout, so the same word is re-issued
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_retry = r_retry;
        w_idx   = r_idx;
        w_dat   = r_dat;
        w_again = r_again;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_state = S_XFER;
                    w_cnt   = '0;
                    w_retry = '0;
                    w_idx   = 4'd0;
                    w_dat   = rom(4'd0);
                    w_again = 1'b0;
                end
            end
            S_XFER: begin
                if (i_wb_ack) begin
                    w_state = S_GAP;
                    w_cnt   = (r_idx == 4'd0) ? CW'(RESET_WAIT) : CW'(GAP_CYCLES);
                    w_retry = '0;
                    w_again = 1'b0;
                end else if (r_cnt >= CW'(TIMEOUT_CYCLES - 1)) begin
                    if (r_retry == RW'(RETRIES)) begin
                        w_state = S_ERROR;
                    end else begin
                        w_state = S_GAP;
                        w_cnt   = CW'(GAP_CYCLES);
                        w_retry = r_retry + 1'b1;
                        w_again = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt <= CW'(1)) begin
                    if (!r_again && r_idx == LAST) begin
                        w_state = S_DONE;
                    end else begin
                        w_state = S_XFER;
                        w_cnt   = '0;
                        w_idx   = r_again ? r_idx : r_idx + 4'd1;
                        w_dat   = rom(w_idx);
                        w_again = 1'b0;
                    end
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign o_wb_dat = r_dat;
    assign o_wb_cyc = (r_state == S_XFER);
    assign o_wb_we  = o_wb_cyc;
    assign o_busy   = (r_state == S_XFER) || (r_state == S_GAP);
    assign o_done   = (r_state == S_DONE);
    assign o_error  = (r_state == S_ERROR);
    assign o_index  = r_idx;
endmodule

// File: tb/tb_rocketcpu_codec_init.sv
// tb_rocketcpu_codec_init: codec init sequencer against a behavioural shifter and a transaction-level model.
`timescale 1ns/1ps
module tb_rocketcpu_codec_init;
    localparam int TO    = 256;
    localparam int GAP   = 16;
    localparam int RWAIT = 1024;
`ifdef CODEC_INIT_RETRY_EN
    localparam int RETRIES = 3;
`else
    localparam int RETRIES = 0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, ack = 1'b0;
    logic [15:0] dat;
    logic we, cyc, busy, done, err;
    logic [3:0] idx;

    always #5 clk = ~clk;

    rocketcpu_codec_init dut (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_start(start),
        .o_wb_dat(dat), .o_wb_we(we), .o_wb_cyc(cyc), .i_wb_ack(ack),
        .o_busy(busy), .o_done(done), .o_error(err), .o_index(idx)
    );

    logic [15:0] rom [11] = '{16'h1E00, 16'h0C00, 16'h0E02, 16'h1000, 16'h0812, 16'h0A00,
                              16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h1201};

    typedef struct {logic [15:0] w; int hi; int lo;} xfer_t;
    typedef struct {int fi; int nf; int l; bit poke; bit e_done; bit e_err; logic [3:0] e_idx;} vec_t;

    xfer_t obs[$], exp_q[$];
    vec_t  vecs[$];
    int n_chk = 0, n_fail = 0;
    int lat = 34, fail_idx = 11, fails = 0, fail_seen = 0;
    int sh_cnt = 0, hi_cnt = 0, lo_cnt = 0, cur_lo = 0, we_bad = 0, dat_bad = 0;
    logic [15:0] cur_w = '0;
    logic prev_cyc = 1'b0;
    bit refuse = 1'b0, hit;

    // shifter: acks lat cycles after cyc rises and holds ack while cyc; monitor records each transfer
    always @(negedge clk) begin
        if (we !== cyc) we_bad++;
        if (cyc) begin
            if (!prev_cyc) begin
                cur_w = dat; hi_cnt = 0; sh_cnt = 0; cur_lo = lo_cnt; lo_cnt = 0;
                hit = (fail_idx < 11) ? (dat == rom[fail_idx]) : 1'b0;
                refuse = hit && (fail_seen < fails);
                if (hit) fail_seen++;
            end
            if (dat !== cur_w) dat_bad++;
            hi_cnt++; sh_cnt++;
            if (sh_cnt >= lat && !refuse) ack = 1'b1;
        end else begin
            if (prev_cyc) obs.push_back('{cur_w, hi_cnt, cur_lo});
            ack = 1'b0;
            lo_cnt++;
        end
        prev_cyc = cyc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // expected transfers: each attempt is {word, cycles with cyc high, idle cycles before it}
    function automatic void model(input int fi, input int nf, input int l, output bit m_done, output int m_idx);
        int gap_before = -1;
        exp_q.delete();
        m_done = 1'b1;
        m_idx = 10;
        for (int i = 0; i < 11; i++) begin
            for (int a = 0; a <= RETRIES; a++) begin
                if (i == fi && a < nf) begin
                    exp_q.push_back('{rom[i], TO, gap_before});
                    gap_before = GAP;
                    if (a == RETRIES) begin
                        m_done = 1'b0;
                        m_idx = i;
                        return;
                    end
                end else begin
                    exp_q.push_back('{rom[i], l, gap_before});
                    gap_before = (i == 0) ? RWAIT : GAP;
                    break;
                end
            end
        end
    endfunction

    task automatic run_seq(input int fi, input int nf, input int l, input bit poke);
        bit m_done;
        int m_idx, k, n;
        bit poked = 1'b0;
        fail_idx = fi; fails = nf; fail_seen = 0; lat = l;
        model(fi, nf, l, m_done, m_idx);
        @(negedge clk);
        obs.delete(); we_bad = 0; dat_bad = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_entry", {8'd0, cyc, busy, done, err, idx, dat}, {8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h1E00});
        k = 0;
        while (!(done || err) && k < 8000) begin
            start = (poke && !poked && busy && !cyc && obs.size() >= 2) ? 1'b1 : 1'b0;
            if (start) poked = 1'b1;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("finish_in_budget", k < 8000, 1);
        repeat (5) @(negedge clk);
        chk("n_words", obs.size(), exp_q.size());
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("word%0d", i), obs[i].w, exp_q[i].w);
            chk($sformatf("cyc_len%0d", i), obs[i].hi, exp_q[i].hi);
            if (exp_q[i].lo >= 0) chk($sformatf("gap_len%0d", i), obs[i].lo, exp_q[i].lo);
        end
        chk("we_eq_cyc", we_bad, 0);
        chk("dat_stable", dat_bad, 0);
        chk("final_status", {busy, done, err, idx}, {1'b0, m_done, !m_done, 4'(m_idx)});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        vec_t v;
        vecs.push_back('{11, 0, 34, 1'b0, 1'b1, 1'b0, 4'd10});
        vecs.push_back('{3, 1000, 34, 1'b0, 1'b0, 1'b1, 4'd3});
`ifdef CODEC_INIT_RETRY_EN
        vecs.push_back('{5, 2, 34, 1'b1, 1'b1, 1'b0, 4'd10});
        vecs.push_back('{5, 4, 34, 1'b0, 1'b0, 1'b1, 4'd5});
        vecs.push_back('{0, 1, 20, 1'b0, 1'b1, 1'b0, 4'd10});
`else
        vecs.push_back('{5, 2, 34, 1'b1, 1'b0, 1'b1, 4'd5});
        vecs.push_back('{0, 1, 20, 1'b0, 1'b0, 1'b1, 4'd0});
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {dat, we, cyc, busy, done, err, idx}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outputs", {dat, we, cyc, busy, done, err, idx}, 0);

        foreach (vecs[i]) begin
            v = vecs[i];
            run_seq(v.fi, v.nf, v.l, v.poke);
            chk($sformatf("vec%0d_status", i), {done, err, idx}, {v.e_done, v.e_err, v.e_idx});
        end

        fail_idx = 11; fails = 0; lat = 34;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!(cyc && idx == 4'd7) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_word7", k < 4000, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_cyc_same_edge", cyc, 0);
        chk("rst_mid_outputs", {dat, we, cyc, busy, done, err, idx}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stays_idle", {dat, we, cyc, busy, done, err, idx}, 0);
        run_seq(11, 0, 34, 1'b0);

        for (int r = 0; r < 4; r++)
            run_seq(int'($urandom_range(0, 11)), int'($urandom_range(0, RETRIES + 1)),
                    int'($urandom_range(2, 50)), bit'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
